// File: rtl/id_ex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_pkg
// Shared definitions for the ID/EX pipeline register of the five-stage MIPS
// core: default widths, register-destination select encodings, the link
// register index, and the ALU class / size control codes produced by the
// decoder. The last two are carried through this stage unchanged; they are
// listed here so that EX and the testbench agree on their meaning.
// ---------------------------------------------------------------------------
package id_ex_stage_reg_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_CNT_DEF  = 16;

  localparam int NB_FUNCT    = 6;
  localparam int NB_ALU_OP   = 3;
  localparam int NB_REG_DST  = 2;
  localparam int NB_SIZE     = 5;

  // Register-destination select. 2'b11 is unused by the decoder and falls
  // back to rt, same as RD_RT.
  typedef enum logic [NB_REG_DST-1:0] {
    RD_RT = 2'b00,
    RD_RA = 2'b01,
    RD_RD = 2'b10
  } reg_dst_e;

  localparam int unsigned LINK_REG = 31;

  // Decoder ALU classes.
  typedef enum logic [NB_ALU_OP-1:0] {
    ALU_OP_MEM   = 3'b000,
    ALU_OP_ADDI  = 3'b001,
    ALU_OP_RTYPE = 3'b010,
    ALU_OP_ANDI  = 3'b011,
    ALU_OP_ORI   = 3'b100,
    ALU_OP_XORI  = 3'b101,
    ALU_OP_LUI   = 3'b110,
    ALU_OP_SLTI  = 3'b111
  } alu_op_e;

  // Load/store size and sign codes.
  typedef enum logic [NB_SIZE-1:0] {
    SIZE_NONE   = 5'b00000,
    SIZE_BYTE_S = 5'b00001,
    SIZE_BYTE_U = 5'b00010,
    SIZE_HALF_S = 5'b00100,
    SIZE_HALF_U = 5'b01000,
    SIZE_WORD   = 5'b10000
  } size_ctrl_e;

  // R-type function codes the bench and EX refer to by name.
  localparam logic [NB_FUNCT-1:0] FUNCT_ADD = 6'h20;
  localparam logic [NB_FUNCT-1:0] FUNCT_SUB = 6'h22;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Pure combinational load-use hazard compare. A load sitting in EX whose
// destination is read by the instruction in ID cannot be forwarded in time,
// so the pipeline must stall for one cycle.
//
// Ports:
//   ex_mem_read  in   instruction in EX is a load
//   ex_dst_reg   in   destination register of the instruction in EX
//   id_rs        in   rs field of the instruction in ID
//   id_rt        in   rt field of the instruction in ID
//   stall        out  hazard detected; hold PC and IF/ID
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_dst_reg,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall
);

  logic dst_nonzero;
  logic dst_match;

  // $0 is hardwired to zero, so a load "into" it never creates a dependency.
  assign dst_nonzero = (ex_dst_reg != '0);
  assign dst_match   = (ex_dst_reg == id_rs) || (ex_dst_reg == id_rt);
  assign stall       = ex_mem_read && dst_nonzero && dst_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register. Latches the decoder's EX/MEM/WB control set,
// register operands, immediate and PC+4; resolves the write destination;
// detects load-use hazards and inserts a bubble (NOP) on a hazard or flush.
// Keeps a saturating count of inserted bubbles for the debug unit.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_enable               pipeline advance; 0 freezes all state
//   i_flush                squash the instruction entering EX
//   i_rs/i_rt/i_rd         instruction register fields
//   i_rs_data/i_rt_data    register file read data
//   i_imm, i_pc_plus4      extended immediate, PC+4 of the ID instruction
//   i_funct, i_alu_op,     decoder outputs carried to EX
//   i_size_control, flags
//   i_reg_dst              destination select (rt / r31 / rd / rt)
//   o_*                    registered copies of the above
//   o_dst_reg              resolved write destination
//   o_stall                load-use hazard (combinational)
//   o_bubble_cnt           bubbles inserted since reset, saturating
// ---------------------------------------------------------------------------
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_flush,

  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  input  logic [NB_DATA-1:0]    i_rs_data,
  input  logic [NB_DATA-1:0]    i_rt_data,
  input  logic [NB_DATA-1:0]    i_imm,
  input  logic [NB_DATA-1:0]    i_pc_plus4,
  input  logic [NB_FUNCT-1:0]   i_funct,
  input  logic                  i_reg_write,
  input  logic                  i_alu_source,
  input  logic                  i_mem_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_mem_read,
  input  logic                  i_link,
  input  logic [NB_ALU_OP-1:0]  i_alu_op,
  input  logic [NB_REG_DST-1:0] i_reg_dst,
  input  logic [NB_SIZE-1:0]    i_size_control,

  output logic [NB_FUNCT-1:0]   o_funct,
  output logic                  o_reg_write,
  output logic                  o_alu_source,
  output logic                  o_mem_write,
  output logic                  o_mem_to_reg,
  output logic                  o_mem_read,
  output logic                  o_link,
  output logic [NB_ALU_OP-1:0]  o_alu_op,
  output logic [NB_SIZE-1:0]    o_size_control,
  output logic [NB_DATA-1:0]    o_rs_data,
  output logic [NB_DATA-1:0]    o_rt_data,
  output logic [NB_DATA-1:0]    o_imm,
  output logic [NB_DATA-1:0]    o_pc_plus4,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_dst_reg,
  output logic                  o_stall,
  output logic [NB_CNT-1:0]     o_bubble_cnt
);

  logic [NB_REG-1:0] dst_resolved;
  logic              load_bubble;
  logic [NB_CNT-1:0] bubble_cnt_next;

  // Destination resolve on the ID-side fields.
  always_comb begin
    dst_resolved = i_rt;
    case (i_reg_dst)
      RD_RA:   dst_resolved = NB_REG'(LINK_REG);
      RD_RD:   dst_resolved = i_rd;
      default: dst_resolved = i_rt;
    endcase
  end

  // Hazard compare uses the registered EX state against the live ID fields,
  // independent of enable/flush so upstream always sees a valid hold request.
  load_use_detect #(
    .NB_REG (NB_REG)
  ) u_load_use_detect (
    .ex_mem_read (o_mem_read),
    .ex_dst_reg  (o_dst_reg),
    .id_rs       (i_rs),
    .id_rt       (i_rt),
    .stall       (o_stall)
  );

  // A flush coinciding with a stall still produces a single bubble.
  assign load_bubble = i_flush || o_stall;

  always_comb begin
    bubble_cnt_next = o_bubble_cnt;
    if (o_bubble_cnt != '1) begin
      bubble_cnt_next = o_bubble_cnt + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_funct        <= '0;
      o_reg_write    <= 1'b0;
      o_alu_source   <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_mem_read     <= 1'b0;
      o_link         <= 1'b0;
      o_alu_op       <= '0;
      o_size_control <= '0;
      o_rs_data      <= '0;
      o_rt_data      <= '0;
      o_imm          <= '0;
      o_pc_plus4     <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_dst_reg      <= '0;
      o_bubble_cnt   <= '0;
    end else if (i_enable) begin
      if (load_bubble) begin
        // Bubble: every field zero, so EX/MEM/WB see a NOP that writes
        // nothing, touches no memory and cannot re-trigger the hazard.
        o_funct        <= '0;
        o_reg_write    <= 1'b0;
        o_alu_source   <= 1'b0;
        o_mem_write    <= 1'b0;
        o_mem_to_reg   <= 1'b0;
        o_mem_read     <= 1'b0;
        o_link         <= 1'b0;
        o_alu_op       <= '0;
        o_size_control <= '0;
        o_rs_data      <= '0;
        o_rt_data      <= '0;
        o_imm          <= '0;
        o_pc_plus4     <= '0;
        o_rs           <= '0;
        o_rt           <= '0;
        o_dst_reg      <= '0;
        o_bubble_cnt   <= bubble_cnt_next;
      end else begin
        o_funct        <= i_funct;
        o_reg_write    <= i_reg_write;
        o_alu_source   <= i_alu_source;
        o_mem_write    <= i_mem_write;
        o_mem_to_reg   <= i_mem_to_reg;
        o_mem_read     <= i_mem_read;
        o_link         <= i_link;
        o_alu_op       <= i_alu_op;
        o_size_control <= i_size_control;
        o_rs_data      <= i_rs_data;
        o_rt_data      <= i_rt_data;
        o_imm          <= i_imm;
        o_pc_plus4     <= i_pc_plus4;
        o_rs           <= i_rs;
        o_rt           <= i_rt;
        o_dst_reg      <= dst_resolved;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed testbench for id_ex_stage_reg with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data, imm, pc_plus4;
  logic [5:0]  funct;
  logic        reg_write, alu_source, mem_write, mem_to_reg, mem_read, link;
  logic [2:0]  alu_op;
  logic [1:0]  reg_dst;
  logic [4:0]  size_control;

  logic [5:0]  o_funct;
  logic        o_reg_write, o_alu_source, o_mem_write, o_mem_to_reg, o_mem_read, o_link;
  logic [2:0]  o_alu_op;
  logic [4:0]  o_size_control;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc_plus4;
  logic [4:0]  o_rs, o_rt, o_dst_reg;
  logic        o_stall;
  logic [15:0] o_bubble_cnt;

  logic [162:0] state_bus;
  int checks = 0;
  int errors = 0;

  assign state_bus = {o_funct, o_reg_write, o_alu_source, o_mem_write, o_mem_to_reg,
                      o_mem_read, o_link, o_alu_op, o_size_control, o_rs_data, o_rt_data,
                      o_imm, o_pc_plus4, o_rs, o_rt, o_dst_reg};

  id_ex_stage_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_imm(imm), .i_pc_plus4(pc_plus4), .i_funct(funct),
    .i_reg_write(reg_write), .i_alu_source(alu_source), .i_mem_write(mem_write),
    .i_mem_to_reg(mem_to_reg), .i_mem_read(mem_read), .i_link(link),
    .i_alu_op(alu_op), .i_reg_dst(reg_dst), .i_size_control(size_control),
    .o_funct(o_funct), .o_reg_write(o_reg_write), .o_alu_source(o_alu_source),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_mem_read(o_mem_read),
    .o_link(o_link), .o_alu_op(o_alu_op), .o_size_control(o_size_control),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc_plus4(o_pc_plus4),
    .o_rs(o_rs), .o_rt(o_rt), .o_dst_reg(o_dst_reg), .o_stall(o_stall),
    .o_bubble_cnt(o_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    enable = 1'b1; flush = 1'b0;
    rs = '0; rt = '0; rd = '0;
    rs_data = '0; rt_data = '0; imm = '0; pc_plus4 = '0; funct = '0;
    reg_write = 1'b0; alu_source = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; mem_read = 1'b0; link = 1'b0;
    alu_op = '0; reg_dst = '0; size_control = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw $dst, 4($29)
  task automatic drive_lw(input logic [4:0] dst);
    clear_inputs();
    rs = 5'd29; rt = dst; reg_dst = RD_RT; imm = 32'd4;
    mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; alu_source = 1'b1;
    alu_op = ALU_OP_MEM; size_control = SIZE_WORD;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    rs = 5'd7; rt = 5'd7; reg_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_bus !== '0) begin
      $display("FAIL reset_state: got %h want 0", state_bus); errors++;
    end
    checks++;
    if (o_bubble_cnt !== 16'd0) begin
      $display("FAIL reset_cnt: got %h want 0000", o_bubble_cnt); errors++;
    end
    checks++;
    if (o_stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", o_stall); errors++;
    end
    #2 rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_normal();
    clear_inputs();
    rs = 5'd1; rt = 5'd2; rd = 5'd3; reg_dst = RD_RD;
    rs_data = 32'h1111_0001; rt_data = 32'h2222_0002;
    reg_write = 1'b1; alu_op = ALU_OP_RTYPE; funct = FUNCT_ADD;
    tick();
    checks++;
    if (o_dst_reg !== 5'd3) begin
      $display("FAIL add_dst: got %0d want 3", o_dst_reg); errors++;
    end
    checks++;
    if (o_reg_write !== 1'b1 || o_funct !== 6'h20 || o_alu_op !== 3'b010) begin
      $display("FAIL add_ctrl: got rw=%b funct=%h op=%b want 1/20/010",
               o_reg_write, o_funct, o_alu_op); errors++;
    end
    checks++;
    if (o_rs_data !== 32'h1111_0001 || o_rt_data !== 32'h2222_0002 || o_rs !== 5'd1 || o_rt !== 5'd2) begin
      $display("FAIL add_data: got %h %h rs=%0d rt=%0d", o_rs_data, o_rt_data, o_rs, o_rt); errors++;
    end
    // reg_dst=11 falls back to rt
    reg_dst = 2'b11; rt = 5'd17; rd = 5'd9;
    tick();
    checks++;
    if (o_dst_reg !== 5'd17) begin
      $display("FAIL dst_sel11: got %0d want 17", o_dst_reg); errors++;
    end
    reg_dst = RD_RT; rt = 5'd6;
    tick();
    checks++;
    if (o_dst_reg !== 5'd6) begin
      $display("FAIL dst_sel00: got %0d want 6", o_dst_reg); errors++;
    end
  endtask

  task automatic test_jal();
    clear_inputs();
    reg_dst = RD_RA; link = 1'b1; reg_write = 1'b1; pc_plus4 = 32'h40;
    rt = 5'd7; rd = 5'd9;
    tick();
    checks++;
    if (o_dst_reg !== 5'd31 || o_pc_plus4 !== 32'h40 || o_link !== 1'b1) begin
      $display("FAIL jal: got dst=%0d pc4=%h link=%b want 31/40/1", o_dst_reg, o_pc_plus4, o_link);
      errors++;
    end
  endtask

  task automatic test_load_use();
    drive_lw(5'd8);
    tick();
    clear_inputs();
    rs = 5'd8; rt = 5'd9; rd = 5'd10; reg_dst = RD_RD;
    reg_write = 1'b1; alu_op = ALU_OP_RTYPE; funct = FUNCT_ADD;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      $display("FAIL lu_stall: got %b want 1", o_stall); errors++;
    end
    tick();
    checks++;
    if (state_bus !== '0 || o_bubble_cnt !== 16'd1) begin
      $display("FAIL lu_bubble: got bus=%h cnt=%0d want 0/1", state_bus, o_bubble_cnt); errors++;
    end
    checks++;
    if (o_stall !== 1'b0) begin
      $display("FAIL lu_stall_drop: got %b want 0", o_stall); errors++;
    end
    tick();
    checks++;
    if (o_rs !== 5'd8 || o_dst_reg !== 5'd10 || o_reg_write !== 1'b1 || o_bubble_cnt !== 16'd1) begin
      $display("FAIL lu_add: got rs=%0d dst=%0d rw=%b cnt=%0d want 8/10/1/1",
               o_rs, o_dst_reg, o_reg_write, o_bubble_cnt); errors++;
    end
  endtask

  task automatic test_zero_reg();
    drive_lw(5'd0);
    tick();
    clear_inputs();
    rs = 5'd0; rt = 5'd0; rd = 5'd11; reg_dst = RD_RD; reg_write = 1'b1;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      $display("FAIL zero_stall: got %b want 0", o_stall); errors++;
    end
    tick();
    checks++;
    if (o_dst_reg !== 5'd11 || o_bubble_cnt !== 16'd1) begin
      $display("FAIL zero_load: got dst=%0d cnt=%0d want 11/1", o_dst_reg, o_bubble_cnt); errors++;
    end
  endtask

  task automatic test_flush_stall();
    drive_lw(5'd12);
    tick();
    clear_inputs();
    rs = 5'd1; rt = 5'd12; rd = 5'd13; reg_dst = RD_RD; reg_write = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin
      $display("FAIL fs_stall: got %b want 1", o_stall); errors++;
    end
    tick();
    flush = 1'b0;
    checks++;
    if (state_bus !== '0 || o_bubble_cnt !== 16'd2) begin
      $display("FAIL fs_bubble: got bus=%h cnt=%0d want 0/2", state_bus, o_bubble_cnt); errors++;
    end
    tick();
    checks++;
    if (o_rt !== 5'd12 || o_dst_reg !== 5'd13 || o_bubble_cnt !== 16'd2) begin
      $display("FAIL fs_reload: got rt=%0d dst=%0d cnt=%0d want 12/13/2", o_rt, o_dst_reg, o_bubble_cnt);
      errors++;
    end
  endtask

  task automatic test_freeze();
    drive_lw(5'd5);
    imm = 32'h1234;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rs = 5'(i + 3); rt = 5'd20; rd = 5'(i); flush = i[0];
      imm = 32'(i); reg_dst = RD_RD; mem_read = ~i[0];
      #1;
      checks++;
      if (o_stall !== (i == 2)) begin
        $display("FAIL freeze_stall[%0d]: got %b want %b", i, o_stall, (i == 2)); errors++;
      end
      tick();
      checks++;
      if (o_dst_reg !== 5'd5 || o_imm !== 32'h1234 || o_mem_read !== 1'b1 ||
          o_rs !== 5'd29 || o_bubble_cnt !== 16'd2) begin
        $display("FAIL freeze_hold[%0d]: got dst=%0d imm=%h mr=%b rs=%0d cnt=%0d",
                 i, o_dst_reg, o_imm, o_mem_read, o_rs, o_bubble_cnt); errors++;
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midstream();
    clear_inputs();
    reg_write = 1'b1; alu_op = ALU_OP_ADDI; alu_source = 1'b1; imm = 32'd5; rt = 5'd4;
    tick();
    checks++;
    if (o_imm !== 32'd5 || o_alu_op !== 3'b001 || o_dst_reg !== 5'd4) begin
      $display("FAIL addi_load: got imm=%0d op=%b dst=%0d want 5/001/4", o_imm, o_alu_op, o_dst_reg);
      errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state_bus !== '0 || o_bubble_cnt !== 16'd0) begin
      $display("FAIL async_reset: got bus=%h cnt=%0d want 0/0", state_bus, o_bubble_cnt); errors++;
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (o_imm !== 32'd5 || o_reg_write !== 1'b1) begin
      $display("FAIL post_reset_load: got imm=%0d rw=%b want 5/1", o_imm, o_reg_write); errors++;
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    flush = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (o_bubble_cnt !== 16'hFFFF) begin
      $display("FAIL sat_reach: got %h want FFFF", o_bubble_cnt); errors++;
    end
    tick();
    checks++;
    if (o_bubble_cnt !== 16'hFFFF || state_bus !== '0) begin
      $display("FAIL sat_hold: got cnt=%h bus=%h want FFFF/0", o_bubble_cnt, state_bus); errors++;
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_jal();
    test_load_use();
    test_zero_reg();
    test_flush_stall();
    test_freeze();
    test_reset_midstream();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
